load_store_master: RTL

- Initiator (CPU) end of the data memory interface; the unified memory is the responder.
- Accepts one MIPS load/store per request from the MEM stage: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Issues word-aligned read/write cycles, honours the responder's busy handshake, and performs sub-word extraction and extension.
- Sub-word stores are done as read-modify-write; alignment errors and bus timeouts are reported back to the pipeline.

---
 rtl/load_store_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_master.sv
// MIPS data-memory initiator: one LB/LBU/LH/LHU/LW/SB/SH/SW per request, word-aligned
// bus cycles with busy handshake, sub-word extract/extend and read-modify-write stores.
module load_store_master #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] vaddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        addr_error,
  output logic        bus_error,
  output logic [31:0] badvaddr,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
  typedef enum logic [2:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_t;

  state_t           state_reg, state_next;
  op_t              op_reg, op_next;
  logic [31:0]      vaddr_reg, vaddr_next;
  logic [15:0]      wdata_reg, wdata_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic [31:0]      badvaddr_reg, badvaddr_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic [31:0]      mem_din_reg, mem_din_next;
  logic             aerr_reg, aerr_next;
  logic             berr_reg, berr_next;

  logic             misaligned;
  logic             timeout;
  logic             is_rmw;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_val;
  logic [31:0]      merged;

  always_comb begin
    misaligned = 1'b0;
    case (op_t'(op))
      OP_LH, OP_LHU, OP_SH: misaligned = vaddr[0];
      OP_LW, OP_SW:         misaligned = |vaddr[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  // The counter saturates at MAX_WAIT, so one more busy cycle there means abort.
  assign timeout = (MAX_WAIT != 0) && (cnt_reg == CNT_W'(MAX_WAIT)) && mem_busy;
  assign is_rmw  = (op_reg == OP_SB) || (op_reg == OP_SH);

  always_comb begin
    lane_byte = mem_dout[7:0];
    case (vaddr_reg[1:0])
      2'd0: lane_byte = mem_dout[7:0];
      2'd1: lane_byte = mem_dout[15:8];
      2'd2: lane_byte = mem_dout[23:16];
      2'd3: lane_byte = mem_dout[31:24];
      default: lane_byte = mem_dout[7:0];
    endcase
    lane_half = vaddr_reg[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (op_reg)
      OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_val = {24'd0, lane_byte};
      OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_val = {16'd0, lane_half};
      default: load_val = mem_dout;
    endcase
  end

  // Byte-lane merge for SB/SH: each lane takes store data or keeps the fetched byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       sel;
      logic [7:0] src;
      assign sel = (op_reg == OP_SB) ? (vaddr_reg[1:0] == 2'(gi))
                                     : (vaddr_reg[1] == 1'(gi / 2));
      assign src = (op_reg == OP_SB) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = sel ? src : mem_dout[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    vaddr_next    = vaddr_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    rdata_next    = rdata_reg;
    badvaddr_next = badvaddr_reg;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    aerr_next     = aerr_reg;
    berr_next     = berr_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next       = op_t'(op);
          vaddr_next    = vaddr;
          wdata_next    = wdata[15:0];
          mem_addr_next = {vaddr[31:2], 2'b00};
          cnt_next      = '0;
          aerr_next     = 1'b0;
          berr_next     = 1'b0;
          if (misaligned) begin
            aerr_next     = 1'b1;
            badvaddr_next = vaddr;
            state_next    = FIN;
          end else if (op_t'(op) == OP_SW) begin
            mem_din_next = wdata;
            state_next   = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (timeout) begin
          berr_next     = 1'b1;
          badvaddr_next = vaddr_reg;
          cnt_next      = '0;
          state_next    = FIN;
        end else if (mem_busy) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          cnt_next = '0;
          if (is_rmw) begin
            mem_din_next = merged;
            state_next   = WRITE;
          end else begin
            rdata_next = load_val;
            state_next = FIN;
          end
        end
      end
      WRITE: begin
        if (timeout) begin
          berr_next     = 1'b1;
          badvaddr_next = vaddr_reg;
          cnt_next      = '0;
          state_next    = FIN;
        end else if (mem_busy) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          cnt_next   = '0;
          state_next = FIN;
        end
      end
      FIN: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= OP_LB;
      vaddr_reg    <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      rdata_reg    <= '0;
      badvaddr_reg <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      aerr_reg     <= 1'b0;
      berr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      vaddr_reg    <= vaddr_next;
      wdata_reg    <= wdata_next;
      cnt_reg      <= cnt_next;
      rdata_reg    <= rdata_next;
      badvaddr_reg <= badvaddr_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
      aerr_reg     <= aerr_next;
      berr_reg     <= berr_next;
    end
  end

  assign rdata      = rdata_reg;
  assign badvaddr   = badvaddr_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign done       = (state_reg == FIN);
  assign addr_error = aerr_reg && (state_reg == FIN);
  assign bus_error  = berr_reg && (state_reg == FIN);
  assign busy       = (state_reg != IDLE);
  assign mem_write  = (state_reg == WRITE);

endmodule
